// File: rtl/seq_detect_param.sv
// Runtime-configurable serial pattern detector with a Mealy match output,
// overlap/non-overlap modes and a saturating match counter.
module seq_detect_param #(
  parameter int unsigned         MAX_LEN = 8,
  parameter int unsigned         CNT_W   = 16,
  parameter logic [MAX_LEN-1:0]  DEF_PAT = 8'b0000_1011,
  parameter int unsigned         DEF_LEN = 4,
  parameter bit                  DEF_OVL = 1'b1,
  localparam int unsigned        LW      = $clog2(MAX_LEN + 1)
) (
  input  logic               clk_i,
  input  logic               clr_i,
  input  logic               valid_i,
  input  logic               input_i,
  input  logic               cfg_load_i,
  input  logic [MAX_LEN-1:0] pat_i,
  input  logic [LW-1:0]      len_i,
  input  logic               overlap_i,
  input  logic               cnt_clr_i,
  output logic               match_o,
  output logic               match_q_o,
  output logic [CNT_W-1:0]   match_cnt_o,
  output logic [LW-1:0]      fill_o,
  output logic               cfg_err_o
);

  localparam logic [MAX_LEN:0] One     = {{MAX_LEN{1'b0}}, 1'b1};
  localparam logic [LW-1:0]    FillMax = LW'(MAX_LEN);
  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [MAX_LEN-1:0] pat_q;
  logic [LW-1:0]      len_q;
  logic               ovl_q;
  logic               err_q;
  logic [LW-1:0]      fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               match_q;

  logic               accepted;
  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN:0]   mask_w;
  logic [MAX_LEN-1:0] mask;
  logic               enough;
  logic               hit;

  assign accepted = valid_i & ~cfg_load_i;
  assign window   = {hist_q[MAX_LEN-2:0], input_i};

  // Mask is one bit wider so a full-length pattern yields all ones.
  assign mask_w = (One << len_q) - One;
  assign mask   = mask_w[MAX_LEN-1:0];

  // fill >= len-1, written as fill+1 >= len to stay unsigned.
  assign enough = ({1'b0, fill_q} + {{LW{1'b0}}, 1'b1}) >= {1'b0, len_q};
  assign hit    = ((window & mask) == (pat_q & mask));

  assign match_o = accepted & ~err_q & enough & hit;

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (cfg_load_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (accepted) begin
      hist_d = window;
      if (match_o && !ovl_q) begin
        fill_d = '0;
      end else if (fill_q != FillMax) begin
        fill_d = fill_q + {{(LW-1){1'b0}}, 1'b1};
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (match_o && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      match_q <= match_o;
    end
  end

  // Active configuration; an illegal length still loads but disables matching.
  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      pat_q <= DEF_PAT;
      len_q <= LW'(DEF_LEN);
      ovl_q <= DEF_OVL;
      err_q <= 1'b0;
    end else if (cfg_load_i) begin
      pat_q <= pat_i;
      len_q <= len_i;
      ovl_q <= overlap_i;
      err_q <= (len_i == '0) || (len_i > FillMax);
    end
  end

  assign match_q_o   = match_q;
  assign match_cnt_o = cnt_q;
  assign fill_o      = fill_q;
  assign cfg_err_o   = err_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: the driver queues hand-derived expectations per
// cycle, a negedge monitor pops and compares them against the DUT outputs.
module tb_seq_detect_param;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       valid = 1'b0;
  logic       din = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] pat = 8'h00;
  logic [3:0] len = 4'd0;
  logic       ovl = 1'b1;
  logic       cnt_clr = 1'b0;
  logic       match;
  logic       match_q;
  logic [3:0] cnt;
  logic [3:0] fill;
  logic       err;

  seq_detect_param #(
    .MAX_LEN(MAX_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i      (clk),
    .clr_i      (clr),
    .valid_i    (valid),
    .input_i    (din),
    .cfg_load_i (cfg_load),
    .pat_i      (pat),
    .len_i      (len),
    .overlap_i  (ovl),
    .cnt_clr_i  (cnt_clr),
    .match_o    (match),
    .match_q_o  (match_q),
    .match_cnt_o(cnt),
    .fill_o     (fill),
    .cfg_err_o  (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic m;
    logic mq;
    int   cnt;
    int   fill;  // -1: not checked
    logic err;
    int   tid;
    int   idx;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Driver-side expectation state
  int   cnt_model = 0;
  logic prev_m = 1'b0;
  logic cur_err = 1'b0;
  int   cur_tid = 0;
  int   cur_idx = 0;

  task automatic chk(input string what, input exp_t e, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s test%0d step%0d: got %0d, expected %0d", what, e.tid, e.idx, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("match_o", e, int'(match), int'(e.m));
      chk("match_q_o", e, int'(match_q), int'(e.mq));
      chk("match_cnt_o", e, int'(cnt), e.cnt);
      chk("cfg_err_o", e, int'(err), int'(e.err));
      if (e.fill >= 0) chk("fill_o", e, int'(fill), e.fill);
    end
  end

  task automatic push(input logic em, input int ef);
    exp_t e;
    e.m    = em;
    e.mq   = prev_m;
    e.cnt  = cnt_model;
    e.fill = ef;
    e.err  = cur_err;
    e.tid  = cur_tid;
    e.idx  = cur_idx;
    cur_idx++;
    sb.push_back(e);
  endtask

  task automatic step(input logic v, input logic b, input logic cc, input logic em, input int ef);
    @(posedge clk);
    #1;
    clr      = 1'b0;
    cfg_load = 1'b0;
    valid    = v;
    din      = b;
    cnt_clr  = cc;
    push(em, ef);
    if (cc) cnt_model = 0;
    else if (em && cnt_model < CNT_MAX) cnt_model++;
    prev_m = em;
  endtask

  // A load cycle also offers a valid bit, which must be discarded.
  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o, input logic new_err);
    @(posedge clk);
    #1;
    clr      = 1'b0;
    cfg_load = 1'b1;
    valid    = 1'b1;
    din      = 1'b1;
    cnt_clr  = 1'b0;
    pat      = p;
    len      = l;
    ovl      = o;
    push(1'b0, -1);
    prev_m  = 1'b0;
    cur_err = new_err;
  endtask

  // Raise clr mid-cycle; outputs are checked at the following negedge, before any clock edge.
  task automatic do_clr();
    @(posedge clk);
    #1;
    clr       = 1'b1;
    valid     = 1'b0;
    cfg_load  = 1'b0;
    cnt_clr   = 1'b0;
    cnt_model = 0;
    prev_m    = 1'b0;
    cur_err   = 1'b0;
    push(1'b0, 0);
  endtask

  // bits/expm are MSB-first: bit 1 of the stream is bits[n-1].
  task automatic stream(input logic [31:0] bits, input logic [31:0] expm, input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, bits[n-1-i], 1'b0, expm[n-1-i], (i == 0) ? 0 : -1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    cur_tid = 0;
    do_clr();

    // 1: default 1011 overlapping
    cur_tid = 1;
    stream(32'b1011011, 32'b0001001, 7);

    // 2: non-overlapping
    cur_tid = 2;
    load(8'h0B, 4'd4, 1'b0, 1'b0);
    stream(32'b1011011, 32'b0001000, 7);
    load(8'h0B, 4'd4, 1'b0, 1'b0);
    stream(32'b10111011, 32'b00010001, 8);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0);

    // 3: gaps of three idle cycles; idle cycles carry a 1 on input_i that must be ignored
    cur_tid = 3;
    load(8'h0B, 4'd4, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, (i == 1) ? 1'b0 : 1'b1, 1'b0, (i == 3), i);
      for (int j = 0; j < 3; j++) step(1'b0, 1'b1, 1'b0, 1'b0, i + 1);
    end

    // 5: async clear in the middle of a partial match
    cur_tid = 5;
    load(8'h0B, 4'd4, 1'b1, 1'b0);
    stream(32'b101, 32'b000, 3);
    do_clr();
    stream(32'b11011, 32'b00001, 5);

    // 6: illegal lengths, then a full-width pattern
    cur_tid = 6;
    load(8'h0B, 4'd0, 1'b1, 1'b1);
    stream(32'b1011, 32'b0000, 4);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4);
    load(8'h0B, 4'd9, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 0);
    load(8'hC3, 4'd8, 1'b1, 1'b0);
    stream(32'b11000011, 32'b00000001, 8);

    // 4: len=1, counter saturation, clear beating a coincident match
    cur_tid = 4;
    load(8'h01, 4'd1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 1'b1, (i < 8) ? i : 8);
    step(1'b1, 1'b1, 1'b1, 1'b1, 8);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8);

    @(posedge clk);
    @(posedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
